// File: rtl/rp_8bit_asm_pkg.sv
// Shared types and per-opcode constants for the AVR instruction encoder.
package rp_8bit_asm_pkg;

  localparam int unsigned OPW = 6;
  localparam int unsigned RW  = 5;
  localparam int unsigned KW  = 22;
  localparam int unsigned BW  = 3;
  localparam int unsigned AW  = 6;
  localparam int unsigned DW  = 16;

  typedef enum logic [OPW-1:0] {
    OP_NOP, OP_CPC, OP_SBC, OP_ADD, OP_CPSE, OP_CP, OP_SUB, OP_ADC,
    OP_AND, OP_EOR, OP_OR, OP_MOV, OP_CPI, OP_SBCI, OP_SUBI, OP_ORI,
    OP_ANDI, OP_LDI, OP_MOVW, OP_RJMP, OP_RCALL, OP_BRBS, OP_BRBC,
    OP_IN, OP_OUT, OP_RET, OP_RETI, OP_JMP, OP_CALL, OP_LDS, OP_STS
  } op_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_W1, ST_W2} state_t;

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [RW-1:0]  rd;
    logic [RW-1:0]  rr;
    logic [KW-1:0]  k;
    logic [BW-1:0]  b;
    logic [AW-1:0]  a;
  } rec_t;

  typedef struct packed {
    logic [DW-1:0] word1;
    logic [DW-1:0] word2;
    logic          two_word;
    logic          illegal;
  } fmt_t;

  localparam logic [DW-1:0] W_NOP  = 16'h0000;
  localparam logic [DW-1:0] W_RET  = 16'h9508;
  localparam logic [DW-1:0] W_RETI = 16'h9518;

  // Opcode nibble of the two-register ALU group
  function automatic logic [3:0] alu_op4(input logic [OPW-1:0] op);
    case (op)
      OP_CPC:  return 4'h1;
      OP_SBC:  return 4'h2;
      OP_ADD:  return 4'h3;
      OP_CPSE: return 4'h4;
      OP_CP:   return 4'h5;
      OP_SUB:  return 4'h6;
      OP_ADC:  return 4'h7;
      OP_AND:  return 4'h8;
      OP_EOR:  return 4'h9;
      OP_OR:   return 4'hA;
      OP_MOV:  return 4'hB;
      default: return 4'h0;
    endcase
  endfunction

  // Top nibble of the register-immediate group
  function automatic logic [3:0] imm_top4(input logic [OPW-1:0] op);
    case (op)
      OP_CPI:  return 4'h3;
      OP_SBCI: return 4'h4;
      OP_SUBI: return 4'h5;
      OP_ORI:  return 4'h6;
      OP_ANDI: return 4'h7;
      OP_LDI:  return 4'hE;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic is_two_word(input logic [OPW-1:0] op);
    return (op == OP_JMP) || (op == OP_CALL) || (op == OP_LDS) || (op == OP_STS);
  endfunction

endpackage

// File: rtl/rp_8bit_asm_fmt.sv
// Combinational record-to-program-word formatter with operand legality check.
module rp_8bit_asm_fmt
  import rp_8bit_asm_pkg::*;
(
  input  rec_t i_rec,
  output fmt_t o_fmt_c
);

  logic w_fit12;
  logic w_fit7;

  // Signed relative offsets fit when all bits above the sign bit match it
  assign w_fit12 = (&i_rec.k[21:11]) | ~(|i_rec.k[21:11]);
  assign w_fit7  = (&i_rec.k[21:6])  | ~(|i_rec.k[21:6]);

  always_comb begin
    o_fmt_c          = '0;
    o_fmt_c.word2    = i_rec.k[15:0];
    o_fmt_c.two_word = is_two_word(i_rec.op);
    case (i_rec.op)
      OP_NOP:  o_fmt_c.word1 = W_NOP;
      OP_CPC, OP_SBC, OP_ADD, OP_CPSE, OP_CP, OP_SUB,
      OP_ADC, OP_AND, OP_EOR, OP_OR, OP_MOV:
        o_fmt_c.word1 = {2'b00, alu_op4(i_rec.op), i_rec.rr[4], i_rec.rd, i_rec.rr[3:0]};
      OP_CPI, OP_SBCI, OP_SUBI, OP_ORI, OP_ANDI, OP_LDI: begin
        o_fmt_c.word1   = {imm_top4(i_rec.op), i_rec.k[7:4], i_rec.rd[3:0], i_rec.k[3:0]};
        o_fmt_c.illegal = ~i_rec.rd[4];
      end
      OP_MOVW: begin
        o_fmt_c.word1   = {8'h01, i_rec.rd[4:1], i_rec.rr[4:1]};
        o_fmt_c.illegal = i_rec.rd[0] | i_rec.rr[0];
      end
      OP_RJMP, OP_RCALL: begin
        o_fmt_c.word1   = {(i_rec.op == OP_RCALL) ? 4'hD : 4'hC, i_rec.k[11:0]};
        o_fmt_c.illegal = ~w_fit12;
      end
      OP_BRBS, OP_BRBC: begin
        o_fmt_c.word1   = {5'b11110, (i_rec.op == OP_BRBC), i_rec.k[6:0], i_rec.b};
        o_fmt_c.illegal = ~w_fit7;
      end
      OP_IN, OP_OUT:
        o_fmt_c.word1 = {4'hB, (i_rec.op == OP_OUT), i_rec.a[5:4], i_rec.rd, i_rec.a[3:0]};
      OP_RET:  o_fmt_c.word1 = W_RET;
      OP_RETI: o_fmt_c.word1 = W_RETI;
      OP_JMP, OP_CALL:
        o_fmt_c.word1 = {7'b1001010, i_rec.k[21:17], 2'b11, (i_rec.op == OP_CALL), i_rec.k[16]};
      OP_LDS, OP_STS:
        o_fmt_c.word1 = {6'b100100, (i_rec.op == OP_STS), i_rec.rd, 4'h0};
      default: o_fmt_c.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rp_8bit_asm_enc.sv
// AVR instruction encoder: accepts instruction records and streams program words with auto-incrementing address.
module rp_8bit_asm_enc
  import rp_8bit_asm_pkg::*;
#(
  parameter int unsigned PAW    = 16,
  parameter bit          ERR_WR = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_adr_set,
  input  logic [PAW-1:0] i_adr_val,
  input  logic           i_in_vld,
  output logic           o_in_rdy_c,
  input  logic [5:0]     i_in_op,
  input  logic [4:0]     i_in_rd,
  input  logic [4:0]     i_in_rr,
  input  logic [21:0]    i_in_k,
  input  logic [2:0]     i_in_b,
  input  logic [5:0]     i_in_a,
  output logic           o_wr_vld,
  input  logic           i_wr_rdy,
  output logic [PAW-1:0] o_wr_adr,
  output logic [15:0]    o_wr_dat,
  output logic           o_err,
  output logic [PAW-1:0] o_cnt
);

  state_t         r_state, w_nxt_state;
  logic           r_wr_vld;
  logic [PAW-1:0] r_wr_adr, w_nxt_adr;
  logic [15:0]    r_wr_dat, w_nxt_dat;
  logic [15:0]    r_w2, w_nxt_w2;
  logic           r_two, w_nxt_two;
  logic           r_err, w_nxt_err;
  logic [PAW-1:0] r_cnt, w_nxt_cnt;

  rec_t        w_rec;
  fmt_t        w_fmt;
  logic        w_acc;
  logic        w_load;
  logic [15:0] w_word1;
  logic        w_two;

  assign w_rec = '{op: i_in_op, rd: i_in_rd, rr: i_in_rr, k: i_in_k, b: i_in_b, a: i_in_a};

  rp_8bit_asm_fmt u_fmt (
    .i_rec   (w_rec),
    .o_fmt_c (w_fmt)
  );

  assign o_in_rdy_c = rst_n & ((r_state == ST_EMPTY) |
                               ((r_state == ST_W1) & i_wr_rdy & ~r_two));
  assign w_acc   = i_in_vld & o_in_rdy_c;
  // Illegal records either vanish or are replaced by a single nop word
  assign w_load  = w_acc & (~w_fmt.illegal | ERR_WR);
  assign w_word1 = w_fmt.illegal ? W_NOP : w_fmt.word1;
  assign w_two   = w_fmt.two_word & ~w_fmt.illegal;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_adr   = r_wr_adr;
    w_nxt_dat   = r_wr_dat;
    w_nxt_w2    = r_w2;
    w_nxt_two   = r_two;
    w_nxt_err   = w_acc & w_fmt.illegal;
    w_nxt_cnt   = w_acc ? r_cnt + PAW'(1) : r_cnt;
    case (r_state)
      ST_EMPTY: begin
        if (i_adr_set) w_nxt_adr = i_adr_val;
        if (w_load) begin
          w_nxt_state = ST_W1;
          w_nxt_dat   = w_word1;
          w_nxt_w2    = w_fmt.word2;
          w_nxt_two   = w_two;
        end
      end
      ST_W1: begin
        if (i_wr_rdy) begin
          w_nxt_adr = r_wr_adr + PAW'(1);
          if (r_two) begin
            w_nxt_state = ST_W2;
            w_nxt_dat   = r_w2;
          end else if (w_load) begin
            w_nxt_dat = w_word1;
            w_nxt_w2  = w_fmt.word2;
            w_nxt_two = w_two;
          end else begin
            w_nxt_state = ST_EMPTY;
          end
        end
      end
      ST_W2: begin
        if (i_wr_rdy) begin
          w_nxt_adr   = r_wr_adr + PAW'(1);
          w_nxt_state = ST_EMPTY;
        end
      end
      default: w_nxt_state = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_EMPTY;
      r_wr_vld <= 1'b0;
      r_wr_adr <= '0;
      r_wr_dat <= '0;
      r_w2     <= '0;
      r_two    <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_nxt_state;
      r_wr_vld <= (w_nxt_state != ST_EMPTY);
      r_wr_adr <= w_nxt_adr;
      r_wr_dat <= w_nxt_dat;
      r_w2     <= w_nxt_w2;
      r_two    <= w_nxt_two;
      r_err    <= w_nxt_err;
      r_cnt    <= w_nxt_cnt;
    end
  end

  assign o_wr_vld = r_wr_vld;
  assign o_wr_adr = r_wr_adr;
  assign o_wr_dat = r_wr_dat;
  assign o_err    = r_err;
  assign o_cnt    = r_cnt;

endmodule
